// File: rtl/uart_pkg.sv
// Shared types and defaults for the transmit-only console UART.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int DEFAULT_CLK_FREQ = 50_000_000;
   localparam int DEFAULT_BAUD     = 115_200;

   // Truncating division: the bit cell is slightly short rather than long.
   function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// DEPTHx8 synchronous FIFO with show-ahead output; pushes while full are dropped.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == CNT_W'(0));
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule

// File: rtl/uart_unit.sv
// Transmit-only 8N1 UART: bus writes queue in a FIFO, the FSM serialises them LSB first.
module uart_unit
   import uart_pkg::*;
#(
   parameter int DEPTH        = 32,
   parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
   parameter int BAUD         = DEFAULT_BAUD,
   parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_fifo_write_en,
   input  logic [7:0] uart_fifo_data,
   output logic       fifo_full,
   output logic       uart_output_line
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   tx_state_t        state_r;
   tx_state_t        state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [2:0]       bit_r;
   logic [2:0]       bit_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_s;
   logic             line_r;
   logic             line_s;
   logic             pop_s;
   logic             cell_done_s;
   logic [7:0]       fifo_dout_s;
   logic             fifo_empty_s;
   logic             fifo_full_s;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (uart_fifo_write_en),
      .pop   (pop_s),
      .din   (uart_fifo_data),
      .dout  (fifo_dout_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   assign cell_done_s      = (cnt_r == LAST_CNT);
   assign fifo_full        = fifo_full_s;
   assign uart_output_line = line_r;

   // Next-state logic: every cell transition restarts the cycle counter.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r + CNT_W'(1);
      bit_s   = bit_r;
      shift_s = shift_r;
      pop_s   = 1'b0;
      case (state_r)
         IDLE: begin
            cnt_s = CNT_W'(0);
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_s = fifo_dout_s;
               state_s = START;
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (cell_done_s) begin
               cnt_s   = CNT_W'(0);
               bit_s   = 3'd0;
               state_s = DATA;
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (cell_done_s) begin
               cnt_s   = CNT_W'(0);
               shift_s = {1'b0, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               state_s = DATA;
            end
         end
         STOP: begin
            if (cell_done_s) begin
               cnt_s   = CNT_W'(0);
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            cnt_s   = CNT_W'(0);
            state_s = IDLE;
         end
      endcase
   end

   // Line level is decoded from the upcoming state so the register updates with it.
   always_comb begin
      line_s = 1'b1;
      case (state_s)
         START:   line_s = 1'b0;
         DATA:    line_s = shift_s[0];
         default: line_s = 1'b1;
      endcase
   end

   // FSM, counters, shift register and the registered serial line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_W'(0);
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         line_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         line_r  <= line_s;
      end
   end

endmodule

// File: tb/tb_uart_unit.sv
// Directed bench for uart_unit: a line decoder pops expected bytes from a scoreboard queue.
module tb_uart_unit;

   localparam int TB_CLK_FREQ = 1_843_200;
   localparam int TB_BAUD     = 115_200;
   localparam int CPB         = 16;
   localparam int FRAME       = 10 * CPB + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   logic       fifo_full;
   logic       line;

   int         pass_cnt = 0;
   int         chk_cnt  = 0;
   int         cyc      = 0;
   logic [7:0] exp_q[$];
   int         starts_q[$];
   int         m_phase = 0;
   int         m_t     = 0;
   int         m_b     = 0;
   logic [7:0] m_byte  = 8'd0;
   logic       full_seen = 1'b0;

   uart_unit #(
      .DEPTH    (32),
      .CLK_FREQ (TB_CLK_FREQ),
      .BAUD     (TB_BAUD)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .uart_fifo_write_en (wr_en),
      .uart_fifo_data     (wr_data),
      .fifo_full          (fifo_full),
      .uart_output_line   (line)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = b;
      @(posedge clk);
   endtask

   task automatic end_writes();
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || m_phase != 0) && n < budget) begin
         @(negedge clk);
         n++;
         if (fifo_full) full_seen = 1'b1;
      end
      chk("drain_timeout", 32'(n < budget), 32'd1);
      repeat (CPB) @(negedge clk);
   endtask

   task automatic check_period(input int n);
      chk("frame_count", 32'(starts_q.size()), 32'(n));
      for (int i = 1; i < starts_q.size(); i++)
         chk("frame_period", 32'(starts_q[i] - starts_q[i-1]), 32'(FRAME));
   endtask

   // Serial decoder: samples each bit cell at its midpoint on the falling clock edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_phase = 0;
         end else if (m_phase == 0) begin
            if (!line) begin
               m_phase = 1;
               m_t     = 0;
               m_byte  = 8'd0;
               starts_q.push_back(cyc);
            end
         end else begin
            m_t++;
            if (m_t % CPB == CPB / 2) begin
               m_b = m_t / CPB;
               if (m_b == 0) begin
                  chk("start_bit", 32'(line), 32'd0);
               end else if (m_b <= 8) begin
                  m_byte[m_b-1] = line;
               end else begin
                  chk("stop_bit", 32'(line), 32'd1);
                  chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                  if (exp_q.size() > 0) chk("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
                  m_phase = 0;
               end
            end
         end
      end
   end

   initial begin
      // Reset held low, then a long idle stretch.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("reset_line", 32'(line), 32'd1);
         chk("reset_full", 32'(fifo_full), 32'd0);
      end
      rst = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i % 10 == 0) chk("idle_line", 32'(line), 32'd1);
      end
      chk("idle_no_frames", 32'(starts_q.size()), 32'd0);

      // Single byte: line falls one edge after the write edge.
      exp_q.push_back(8'hA5);
      write_byte(8'hA5);
      end_writes();
      chk("latency_write_edge", 32'(line), 32'd1);
      @(negedge clk);
      chk("latency_pop_edge", 32'(line), 32'd0);
      wait_frames(2 * FRAME);
      chk("single_idle_line", 32'(line), 32'd1);

      // Back-to-back frames of alternating all-ones / all-zeros.
      starts_q.delete();
      full_seen = 1'b0;
      exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      write_byte(8'hFF); write_byte(8'h00); write_byte(8'hFF); write_byte(8'h00);
      end_writes();
      wait_frames(5 * FRAME);
      chk("b2b_full_never", 32'(full_seen), 32'd0);
      check_period(4);
      chk("b2b_idle_line", 32'(line), 32'd1);

      // Overflow: 33 writes fill the FIFO, a 34th is dropped.
      starts_q.delete();
      for (int i = 0; i <= 32; i++) exp_q.push_back(8'(i));
      for (int i = 0; i <= 32; i++) write_byte(8'(i));
      @(negedge clk);
      chk("full_after_33", 32'(fifo_full), 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'h55;
      @(posedge clk);
      end_writes();
      repeat (10 * CPB - 32) @(negedge clk);
      chk("full_before_pop2", 32'(fifo_full), 32'd1);
      @(negedge clk);
      chk("full_after_pop2", 32'(fifo_full), 32'd0);
      wait_frames(34 * FRAME);
      check_period(33);
      chk("overflow_drained_full", 32'(fifo_full), 32'd0);

      // Reset during the data bits of 0x0F with three bytes still queued.
      write_byte(8'h0F); write_byte(8'h01); write_byte(8'h02); write_byte(8'h03);
      end_writes();
      repeat (3 * CPB) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midreset_line", 32'(line), 32'd1);
      chk("midreset_full", 32'(fifo_full), 32'd0);
      repeat (3) @(negedge clk);
      chk("midreset_hold_line", 32'(line), 32'd1);
      rst = 1'b1;
      starts_q.delete();
      repeat (3 * FRAME) @(negedge clk);
      chk("midreset_no_frames", 32'(starts_q.size()), 32'd0);
      chk("midreset_line_idle", 32'(line), 32'd1);
      chk("midreset_full_after", 32'(fifo_full), 32'd0);

      // Push in the same cycle IDLE pops the previous byte.
      starts_q.delete();
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h3C);
      write_byte(8'h11);
      write_byte(8'h3C);
      end_writes();
      wait_frames(3 * FRAME);
      repeat (2 * FRAME) @(negedge clk);
      check_period(2);
      chk("simul_full", 32'(fifo_full), 32'd0);
      chk("simul_idle_line", 32'(line), 32'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
